// File: rtl/spi_sub_ctrl.sv
// SPI mode-0 subordinate: synchronizes sclk/cs/mosi to clk, shifts a held tx word out on MISO
// and assembles received words with a one-clk new_value strobe. Define SPI_SUB_MISO_TRISTATE_EN to float MISO when not busy.
module spi_sub_ctrl #(
  parameter int SHIFT_REG_WIDTH = 8,
  parameter bit MSB_FIRST       = 1'b1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spi_sclk,
  input  logic                       spi_cs,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  input  logic [SHIFT_REG_WIDTH-1:0] data_to_send,
  input  logic                       load,
  output logic [SHIFT_REG_WIDTH-1:0] data_received,
  output logic                       new_value,
  output logic                       busy
);
  localparam int W  = SHIFT_REG_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
  logic [W-1:0]           hold_buf, tx_shift, tx_shift_nxt, tx_adv;
  logic [W-1:0]           rx_shift, rx_shift_nxt, rx_adv, data_received_nxt;
  logic [CW-1:0]          bit_cnt, bit_cnt_nxt, cnt_inc;
  logic                   miso_q, miso_nxt, new_value_nxt;

  function automatic logic first_bit(input logic [W-1:0] v);
    return MSB_FIRST ? v[W-1] : v[0];
  endfunction

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // CS synchronizer clears low so a frame in progress at reset release is never joined.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_buf <= '0;
    else if (load) hold_buf <= data_to_send;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_CS_HIGH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    tx_shift_nxt      = tx_shift;
    rx_shift_nxt      = rx_shift;
    bit_cnt_nxt       = bit_cnt;
    miso_nxt          = miso_q;
    data_received_nxt = data_received;
    new_value_nxt     = 1'b0;
    tx_adv            = MSB_FIRST ? {tx_shift[W-2:0], 1'b0} : {1'b0, tx_shift[W-1:1]};
    rx_adv            = MSB_FIRST ? {rx_shift[W-2:0], mosi_s} : {mosi_s, rx_shift[W-1:1]};
    cnt_inc           = bit_cnt + CW'(1);
    case (state)
      WAIT_CS_HIGH: begin
        miso_nxt = 1'b0;
        if (cs_s) state_nxt = IDLE;
      end
      IDLE: begin
        miso_nxt = 1'b0;
        if (!cs_s) begin
          tx_shift_nxt = hold_buf;
          miso_nxt     = first_bit(hold_buf);
          bit_cnt_nxt  = '0;
          state_nxt    = ACTIVE;
        end
      end
      ACTIVE: begin
        // CS release takes priority over any coincident sclk edge.
        if (cs_s) begin
          state_nxt   = IDLE;
          miso_nxt    = 1'b0;
          bit_cnt_nxt = '0;
        end else if (sclk_rise) begin
          rx_shift_nxt = rx_adv;
          if (cnt_inc == CW'(W)) begin
            data_received_nxt = rx_adv;
            new_value_nxt     = 1'b1;
            bit_cnt_nxt       = '0;
          end else begin
            bit_cnt_nxt = cnt_inc;
          end
        end else if (sclk_fall) begin
          if (bit_cnt != '0) begin
            tx_shift_nxt = tx_adv;
            miso_nxt     = first_bit(tx_adv);
          end else begin
            tx_shift_nxt = hold_buf;
            miso_nxt     = first_bit(hold_buf);
          end
        end
      end
      default: state_nxt = WAIT_CS_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      miso_q        <= 1'b0;
      data_received <= '0;
      new_value     <= 1'b0;
    end else begin
      tx_shift      <= tx_shift_nxt;
      rx_shift      <= rx_shift_nxt;
      bit_cnt       <= bit_cnt_nxt;
      miso_q        <= miso_nxt;
      data_received <= data_received_nxt;
      new_value     <= new_value_nxt;
    end
  end

  assign busy = (state == ACTIVE);

`ifdef SPI_SUB_MISO_TRISTATE_EN
  assign spi_miso = busy ? miso_q : 1'bz;
`else
  assign spi_miso = busy ? miso_q : 1'b0;
`endif

endmodule

// File: tb/tb_spi_sub_ctrl.sv
// Bench for spi_sub_ctrl: MSB-first and LSB-first instances share one SPI bus; a word-level
// model (expected-word queues and held values) is checked every clk, plus literal frame checks.
module tb_spi_sub_ctrl;
  localparam int W    = 8;
  localparam int HALF = 50;
`ifdef SPI_SUB_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         spi_sclk = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
  logic [W-1:0] data_to_send = '0;
  logic         load = 1'b0;
  logic         miso_a, miso_b, nv_a, nv_b, busy_a, busy_b;
  logic [W-1:0] rx_a, rx_b;

  int           total = 0, bad = 0;
  logic [W-1:0] exp_a[$], exp_b[$];
  logic [W-1:0] last_a = '0, last_b = '0;
  logic         rst_prev = 1'b1;

  always #5 clk = ~clk;

  spi_sub_ctrl #(.SHIFT_REG_WIDTH(W), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(miso_a), .data_to_send(data_to_send), .load(load),
    .data_received(rx_a), .new_value(nv_a), .busy(busy_a));

  spi_sub_ctrl #(.SHIFT_REG_WIDTH(W), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(miso_b), .data_to_send(data_to_send), .load(load),
    .data_received(rx_b), .new_value(nv_b), .busy(busy_b));

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    data_to_send = v;
    load = 1'b1;
    wait_clk(1);
    load = 1'b0;
  endtask

  // Main side, mode 0: mosi changes while sclk low, miso sampled at the rising edge, MSB of 'mo' first.
  task automatic send_word(input logic [W-1:0] mo, input bit do_ld, input logic [W-1:0] ld_val,
                           input int nbits, output logic [W-1:0] got_a, output logic [W-1:0] got_b);
    got_a = '0;
    got_b = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[W-1-i];
      wait_clk(HALF);
      got_a = {got_a[W-2:0], miso_a};
      got_b = {got_b[W-2:0], miso_b};
      spi_sclk = 1'b1;
      if (do_ld && i == nbits - 1) begin
        wait_clk(10);
        do_load(ld_val);
        wait_clk(HALF - 11);
      end else begin
        wait_clk(HALF);
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [W-1:0] main_word);
    exp_a.push_back(main_word);
    exp_b.push_back(bitrev(main_word));
  endtask

  task automatic end_frame();
    wait_clk(HALF);
    spi_cs = 1'b1;
    wait_clk(2 * HALF);
  endtask

  // Per-clk model check: data_received only moves together with new_value, and only to the next queued word.
  initial begin
    logic [W-1:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        check("reset rx_a", rx_a, '0);
        check("reset rx_b", rx_b, '0);
        check("reset nv_a/busy_a", {nv_a, busy_a}, '0);
        check("reset nv_b/busy_b", {nv_b, busy_b}, '0);
        last_a = '0;
        last_b = '0;
      end else begin
        if (nv_a === 1'b1) begin
          if (exp_a.size() == 0) begin
            total++; bad++;
            if (bad <= 20) $display("FAIL unexpected new_value a: data %h, none expected", rx_a);
          end else begin
            e = exp_a.pop_front();
            check("word a", rx_a, e);
            last_a = e;
          end
        end else begin
          check("hold a", {rx_a[W-2:0], nv_a}, {last_a[W-2:0], 1'b0});
          check("hold a msb", {7'd0, rx_a[W-1]}, {7'd0, last_a[W-1]});
        end
        if (nv_b === 1'b1) begin
          if (exp_b.size() == 0) begin
            total++; bad++;
            if (bad <= 20) $display("FAIL unexpected new_value b: data %h, none expected", rx_b);
          end else begin
            e = exp_b.pop_front();
            check("word b", rx_b, e);
            last_b = e;
          end
        end else begin
          check("hold b", {rx_b[W-2:0], nv_b}, {last_b[W-2:0], 1'b0});
          check("hold b msb", {7'd0, rx_b[W-1]}, {7'd0, last_b[W-1]});
        end
      end
      rst_prev = rst;
    end
  end

  initial begin
    logic [W-1:0] ga, gb, g1a, g1b, g2a, g2b, g3a, g3b, pat;
    wait_clk(2);
    rst = 1'b0;
    check("rst rx_a", rx_a, 8'h00);
    check("rst miso_a", {7'd0, miso_a}, {7'd0, MISO_IDLE});
    check("rst miso_b", {7'd0, miso_b}, {7'd0, MISO_IDLE});
    check("rst busy_a", {7'd0, busy_a}, 8'h00);
    wait_clk(10);

    // Single word.
    do_load(8'h3C);
    push_exp(8'hA5);
    spi_cs = 1'b0;
    wait_clk(HALF);
    check("busy_a in frame", {7'd0, busy_a}, 8'h01);
    check("busy_b in frame", {7'd0, busy_b}, 8'h01);
    send_word(8'hA5, 1'b0, '0, 8, ga, gb);
    check("single miso a", ga, 8'h3C);
    check("single miso b", gb, 8'h3C);
    end_frame();
    check("busy_a after cs", {7'd0, busy_a}, 8'h00);
    check("single rx_a", rx_a, 8'hA5);
    check("single pending", W'(exp_a.size() + exp_b.size()), 8'd0);

    // Burst of three words with reloads between them.
    do_load(8'h11);
    push_exp(8'h01); push_exp(8'h02); push_exp(8'h03);
    spi_cs = 1'b0;
    wait_clk(HALF);
    send_word(8'h01, 1'b1, 8'h22, 8, g1a, g1b);
    send_word(8'h02, 1'b1, 8'h33, 8, g2a, g2b);
    send_word(8'h03, 1'b0, '0, 8, g3a, g3b);
    check("burst miso a0", g1a, 8'h11);
    check("burst miso a1", g2a, 8'h22);
    check("burst miso a2", g3a, 8'h33);
    check("burst miso b0", g1b, 8'h88);
    check("burst miso b1", g2b, 8'h44);
    check("burst miso b2", g3b, 8'hCC);
    end_frame();
    check("burst rx_a", rx_a, 8'h03);
    check("burst rx_b", rx_b, 8'hC0);
    check("burst pending", W'(exp_a.size() + exp_b.size()), 8'd0);

    // Aborted frame, then a full frame resending the unreloaded buffer.
    spi_cs = 1'b0;
    wait_clk(HALF);
    send_word(8'hFF, 1'b0, '0, 5, ga, gb);
    end_frame();
    check("abort rx_a", rx_a, 8'h03);
    check("abort rx_b", rx_b, 8'hC0);
    push_exp(8'h5A);
    spi_cs = 1'b0;
    wait_clk(HALF);
    send_word(8'h5A, 1'b0, '0, 8, ga, gb);
    check("resend miso a", ga, 8'h33);
    check("resend miso b", gb, 8'hCC);
    end_frame();
    check("after abort rx_a", rx_a, 8'h5A);

    // Reset in the middle of a frame; remainder of frame ignored.
    spi_cs = 1'b0;
    wait_clk(HALF);
    send_word(8'hFF, 1'b0, '0, 3, ga, gb);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(5);
    check("midrst busy_a", {7'd0, busy_a}, 8'h00);
    check("midrst miso_a", {7'd0, miso_a}, {7'd0, MISO_IDLE});
    send_word(8'hFF, 1'b0, '0, 5, ga, gb);
    check("midrst busy_a late", {7'd0, busy_a}, 8'h00);
    end_frame();
    check("midrst rx_a", rx_a, 8'h00);
    push_exp(8'hC3);
    spi_cs = 1'b0;
    wait_clk(HALF);
    send_word(8'hC3, 1'b0, '0, 8, ga, gb);
    check("post-rst miso a", ga, 8'h00);
    end_frame();
    check("post-rst rx_a", rx_a, 8'hC3);

    // LSB-first: main sends 0x01 LSB-first, dut_b holds 0x80.
    do_load(8'h80);
    push_exp(8'h80);
    spi_cs = 1'b0;
    wait_clk(HALF);
    send_word(8'h80, 1'b0, '0, 8, ga, gb);
    end_frame();
    check("lsb rx_b", rx_b, 8'h01);
    check("lsb rx_a", rx_a, 8'h80);
    pat = 8'h80;
    for (int i = 0; i < W; i++)
      check("lsb miso bit", {7'd0, gb[W-1-i]}, {7'd0, pat[i]});
    check("final pending", W'(exp_a.size() + exp_b.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
